// File: rtl/ternary_lane_feeder_pkg.sv
// Shared ternary definitions: trit encodings and the feeder state enumeration,
// also consumed by the lane ALU.
package ternary_lane_feeder_pkg;

  typedef enum logic [1:0] {
    ZERO    = 2'b00,
    POS     = 2'b01,
    NEG     = 2'b10,
    ILLEGAL = 2'b11
  } trit_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  function automatic logic is_illegal(input logic [1:0] code);
    return code == ILLEGAL;
  endfunction

endpackage

// File: rtl/ternary_lane_feeder_if.sv
// Upstream word-pair handshake between the trit source and the lane feeder.
interface ternary_lane_feeder_if #(
  parameter int unsigned TRITS_PER_WORD = 16
);
  logic                          s_valid;
  logic                          s_ready;
  logic [2*TRITS_PER_WORD-1:0]   s_weight;
  logic [2*TRITS_PER_WORD-1:0]   s_trit;

  modport master (output s_valid, s_weight, s_trit, input s_ready);
  modport slave  (input s_valid, s_weight, s_trit, output s_ready);
endinterface

// File: rtl/ternary_lane_feeder_sanitizer.sv
// Combinational trit code check: illegal codes are flagged and replaced by zero.
module ternary_trit_sanitizer
  import ternary_lane_feeder_pkg::*;
(
  input  logic [1:0] code,
  output logic [1:0] trit,
  output logic       illegal
);
  always_comb begin
    illegal = is_illegal(code);
    trit    = illegal ? ZERO : code;
  end
endmodule

// File: rtl/ternary_lane_feeder.sv
// Unpacks buffered weight/input words into one trit pair per cycle for a lane ALU,
// counting down a tile length and flagging illegal codes.
module ternary_lane_feeder
  import ternary_lane_feeder_pkg::*;
#(
  parameter int unsigned TRITS_PER_WORD = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] tile_len,
  ternary_lane_feeder_if.slave s,
  output logic [1:0]       weight_out,
  output logic [1:0]       trit_out,
  output logic             enable_out,
  output logic             busy,
  output logic             tile_done,
  output logic [CNT_W-1:0] invalid_count
);
  localparam int unsigned       PTR_W     = (TRITS_PER_WORD > 1) ? $clog2(TRITS_PER_WORD) : 1;
  localparam int unsigned       SUM_W     = CNT_W + 1;
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(TRITS_PER_WORD - 1);

  state_e                      state, state_nxt;
  logic [2*TRITS_PER_WORD-1:0] buf_w, buf_t;
  logic                        full;
  logic [PTR_W-1:0]            ptr;
  logic [CNT_W-1:0]            remain;
  logic                        issue, last_pair, slot_end, xfer, accept_start;
  logic [1:0]                  raw_w, raw_t, cln_w, cln_t;
  logic                        ill_w, ill_t;
  logic [SUM_W-1:0]            inv_sum;
  logic [CNT_W-1:0]            inv_next;

  always_comb begin
    accept_start = start && (state == IDLE);
    issue        = (state == STREAM) && full && (remain != '0);
    last_pair    = issue && (remain == CNT_W'(1));
    slot_end     = (ptr == LAST_SLOT);
    // Refill in the same cycle the buffer's final needed slot issues, unless the tile ends there.
    s.s_ready    = !reset && (state == STREAM) && (remain != '0) &&
                   (!full || (issue && slot_end && !last_pair));
    xfer         = s.s_valid && s.s_ready;
    raw_w        = buf_w[{ptr, 1'b0} +: 2];
    raw_t        = buf_t[{ptr, 1'b0} +: 2];
    busy         = (state != IDLE);
    tile_done    = (state == DONE);
    inv_sum      = {1'b0, invalid_count} + SUM_W'(ill_w) + SUM_W'(ill_t);
    inv_next     = inv_sum[CNT_W] ? '1 : inv_sum[CNT_W-1:0];
  end

  ternary_trit_sanitizer u_san_w (.code(raw_w), .trit(cln_w), .illegal(ill_w));
  ternary_trit_sanitizer u_san_t (.code(raw_t), .trit(cln_t), .illegal(ill_t));

  // STREAM leaves one cycle after the last pair issues so tile_done follows the last enable_out.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (tile_len != '0) ? STREAM : DONE;
      STREAM:  if (remain == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_w         <= '0;
      buf_t         <= '0;
      full          <= 1'b0;
      ptr           <= '0;
      remain        <= '0;
      weight_out    <= ZERO;
      trit_out      <= ZERO;
      enable_out    <= 1'b0;
      invalid_count <= '0;
    end else begin
      weight_out <= issue ? cln_w : ZERO;
      trit_out   <= issue ? cln_t : ZERO;
      enable_out <= issue;

      if (accept_start)  remain <= tile_len;
      else if (issue)    remain <= remain - CNT_W'(1);

      if (xfer) begin
        buf_w <= s.s_weight;
        buf_t <= s.s_trit;
        full  <= 1'b1;
        ptr   <= '0;
      end else if (last_pair || (issue && slot_end)) begin
        full  <= 1'b0;
        ptr   <= '0;
      end else if (issue) begin
        ptr   <= ptr + PTR_W'(1);
      end

      if (issue) invalid_count <= inv_next;
    end
  end

endmodule

// File: tb/tb_ternary_lane_feeder.sv
// Directed and randomized bench for ternary_lane_feeder against a queue-based pair model.
module tb_ternary_lane_feeder;
  import ternary_lane_feeder_pkg::*;

  localparam int unsigned T  = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [CW-1:0] tile_len;
  logic [1:0]    weight_out, trit_out;
  logic          enable_out, busy, tile_done;
  logic [CW-1:0] invalid_count;

  ternary_lane_feeder_if #(.TRITS_PER_WORD(T)) sif ();

  ternary_lane_feeder #(.TRITS_PER_WORD(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .tile_len(tile_len), .s(sif),
    .weight_out(weight_out), .trit_out(trit_out), .enable_out(enable_out),
    .busy(busy), .tile_done(tile_done), .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tcount = 0;
  // Reference model: expected pair stream built from offered words and the tile length.
  logic [1:0]     qw[$], qt[$];
  logic [2*T-1:0] ow_w[$], ow_t[$];
  int  len, pushed, popped, exp_inv;
  bit  active, done_due, leaving, feed_en, rand_gap;
  int  en_total, cur_run, max_run, xfers, first_xfer_tick, first_en_tick;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*T-1:0] gen_word(input bit allow_ill);
    logic [2*T-1:0] w;
    for (int k = 0; k < T; k++) w[2*k +: 2] = 2'($urandom_range(allow_ill ? 3 : 2, 0));
    return w;
  endfunction

  task automatic model_reset();
    qw.delete(); qt.delete();
    active = 0; done_due = 0; leaving = 0; exp_inv = 0;
    len = 0; pushed = 0; popped = 0;
    en_total = 0; cur_run = 0; max_run = 0; xfers = 0;
  endtask

  task automatic drive();
    sif.s_valid  = feed_en && (ow_w.size() > 0) && (!rand_gap || ($urandom_range(1, 0) == 1));
    sif.s_weight = (ow_w.size() > 0) ? ow_w[0] : '0;
    sif.s_trit   = (ow_t.size() > 0) ? ow_t[0] : '0;
  endtask

  task automatic check();
    logic [1:0] rw, rt;
    if (leaving) begin active = 0; leaving = 0; end
    chk("busy", busy, active);
    chk("tile_done", tile_done, done_due);
    if (done_due) begin leaving = 1; done_due = 0; end
    if (enable_out === 1'b1) begin
      en_total++; cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (qw.size() == 0) chk("spurious_enable", enable_out, 0);
      else begin
        rw = qw.pop_front(); rt = qt.pop_front();
        if (popped == 0) first_en_tick = tcount;
        popped++;
        chk("weight_out", weight_out, (rw == 2'b11) ? 2'b00 : rw);
        chk("trit_out", trit_out, (rt == 2'b11) ? 2'b00 : rt);
        exp_inv += int'(rw == 2'b11) + int'(rt == 2'b11);
        if (exp_inv > 65535) exp_inv = 65535;
        if (popped == len) done_due = 1;
      end
    end else begin
      cur_run = 0;
      chk("idle_outputs", {enable_out, weight_out, trit_out}, 0);
    end
    chk("invalid_count", invalid_count, exp_inv);
  endtask

  task automatic tick();
    logic [2*T-1:0] w, t;
    @(negedge clk);
    if (reset) model_reset();
    else begin
      if (start && !active) begin
        active = 1; len = int'(tile_len); pushed = 0; popped = 0;
        en_total = 0; cur_run = 0; max_run = 0; xfers = 0;
        if (len == 0) done_due = 1;
      end
      if (sif.s_valid && sif.s_ready) begin
        xfers++;
        if (xfers == 1) first_xfer_tick = tcount;
        w = ow_w.pop_front(); t = ow_t.pop_front();
        for (int k = 0; k < T; k++)
          if (pushed < len) begin
            qw.push_back(w[2*k +: 2]); qt.push_back(t[2*k +: 2]); pushed++;
          end
      end
    end
    @(posedge clk); #1;
    tcount++;
    check();
    drive();
  endtask

  task automatic begin_tile(input int l);
    tile_len = CW'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_tile(input int budget);
    int n = 0;
    while (active && n < budget) begin tick(); n++; end
    checks++;
    assert (!active) else begin errors++; $error("FAIL tile_timeout: observed busy expected idle"); end
  endtask

  task automatic clear_words();
    ow_w.delete(); ow_t.delete(); drive();
  endtask

  initial begin
    int n, nw, l;
    logic [2*T-1:0] w, t;
    reset = 1'b1; start = 1'b0; tile_len = '0; feed_en = 0; rand_gap = 0;
    model_reset();
    drive();
    // Reset state, with a word offered that must not be taken.
    ow_w.push_back(gen_word(0)); ow_t.push_back(gen_word(0)); feed_en = 1; drive();
    tick(); tick();
    chk("reset_s_ready", sif.s_ready, 0);
    reset = 1'b0; clear_words();
    tick();
    chk("idle_s_ready", sif.s_ready, 0);

    // One word: weights all +1, inputs alternating +1/-1.
    ow_w.push_back({T{2'b01}}); ow_t.push_back({(T/2){4'b1001}}); drive();
    begin_tile(16);
    run_tile(100);
    chk("t1_pairs", en_total, 16);
    chk("t1_contiguous", max_run, 16);
    chk("t1_latency", first_en_tick - first_xfer_tick, 2);

    // Three words continuously plus a spare: tail of word 3 discarded, spare never taken.
    for (int i = 0; i < 4; i++) begin ow_w.push_back(gen_word(0)); ow_t.push_back(gen_word(0)); end
    drive();
    begin_tile(40);
    run_tile(200);
    chk("t2_pairs", en_total, 40);
    chk("t2_contiguous", max_run, 40);
    chk("t2_xfers", xfers, 3);
    chk("t2_spare_left", ow_w.size(), 1);
    clear_words();

    // Valid dropped after the first word: stall with zeroed outputs.
    for (int i = 0; i < 2; i++) begin ow_w.push_back(gen_word(0)); ow_t.push_back(gen_word(0)); end
    drive();
    begin_tile(20);
    n = 0;
    while (xfers < 1 && n < 20) begin tick(); n++; end
    chk("t3_first_xfer", xfers, 1);
    tick(); tick(); tick();
    feed_en = 0; drive();
    repeat (20) tick();
    feed_en = 1; drive();
    run_tile(200);
    chk("t3_pairs", en_total, 20);
    chk("t3_stalled", max_run < 20, 1);

    // Illegal codes: weight slots 2 and 5, input slot 5.
    w = gen_word(0); t = gen_word(0);
    w[5:4] = 2'b11; w[11:10] = 2'b11; t[11:10] = 2'b11;
    ow_w.push_back(w); ow_t.push_back(t); drive();
    begin_tile(16);
    run_tile(100);
    chk("t4_invalid_count", invalid_count, 3);

    // Zero-length tile: immediate tile_done, nothing taken.
    ow_w.push_back(gen_word(0)); ow_t.push_back(gen_word(0)); drive();
    begin_tile(0);
    run_tile(10);
    chk("t5_no_xfer", xfers, 0);
    chk("t5_no_enable", en_total, 0);
    // Start during STREAM is ignored.
    begin_tile(16);
    n = 0;
    while (en_total < 4 && n < 50) begin tick(); n++; end
    tile_len = CW'(5); start = 1'b1; tick(); start = 1'b0;
    run_tile(100);
    chk("t5_len_kept", en_total, 16);
    clear_words();

    // Reset after 7 of 16 pairs, then a full tile.
    ow_w.push_back(gen_word(1)); ow_t.push_back(gen_word(1)); drive();
    begin_tile(16);
    n = 0;
    while (en_total < 7 && n < 50) begin tick(); n++; end
    chk("t6_seven_pairs", en_total, 7);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_reset_outputs", {sif.s_ready, enable_out, weight_out, trit_out, busy, tile_done}, 0);
    chk("t6_reset_inv", invalid_count, 0);
    clear_words();
    ow_w.push_back(gen_word(1)); ow_t.push_back(gen_word(1)); drive();
    begin_tile(16);
    run_tile(100);
    chk("t6_full_tile", en_total, 16);

    // Random tiles with random valid gaps and illegal codes.
    rand_gap = 1;
    for (int r = 0; r < 6; r++) begin
      l  = $urandom_range(50, 1);
      nw = (l + T - 1) / T;
      for (int i = 0; i <= nw; i++) begin ow_w.push_back(gen_word(1)); ow_t.push_back(gen_word(1)); end
      drive();
      begin_tile(l);
      run_tile(600);
      chk("rnd_pairs", en_total, l);
      chk("rnd_xfers", xfers, nw);
      clear_words();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_lane_feeder.md
TERNARY_LANE_FEEDER -- requirements
Module: ternary_lane_feeder

Interface
REQ-001 Parameter TRITS_PER_WORD, default 16: 2-bit trit slots per packed input word.
REQ-002 Parameter CNT_W, default 16: width of tile length and counters.
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle pulse that begins a tile.
REQ-006 Port tile_len  input  CNT_W: number of weight/input trit pairs in the tile, sampled on start.
REQ-007 Port s_valid  input  1: upstream word pair valid.
REQ-008 Port s_ready  output  1: feeder accepts a word pair this cycle.
REQ-009 Port s_weight  input  2*TRITS_PER_WORD: packed weights, slot 0 in bits [1:0].
REQ-010 Port s_trit  input  2*TRITS_PER_WORD: packed inputs, same slot order.
REQ-011 Port weight_out  output  2: weight trit to the lane ALU (00=0, 01=+1, 10=-1).
REQ-012 Port trit_out  output  2: input trit to the lane ALU, same encoding.
REQ-013 Port enable_out  output  1: weight_out/trit_out carry a valid pair this cycle.
REQ-014 Port busy  output  1: tile in progress.
REQ-015 Port tile_done  output  1: one-cycle pulse after the last pair of a tile is issued.
REQ-016 Port invalid_count  output  CNT_W: saturating count of illegal 2'b11 codes seen.

Function
REQ-017 States IDLE, STREAM, DONE; IDLE->STREAM on start with tile_len>0; IDLE->DONE on start with tile_len==0; STREAM->DONE when the last pair issues; DONE->IDLE unconditionally after one cycle.
REQ-018 start while busy is ignored; tile_len is latched only on accepted start.
REQ-019 Handshake: transfer occurs on an edge where s_valid and s_ready are both 1; s_ready is 0 in IDLE and DONE.
REQ-020 Single word-pair buffer plus slot pointer; s_ready=1 in STREAM when the buffer is empty or its final needed slot issues this cycle, giving gap-free back-to-back words.
REQ-021 Slots issue in ascending order (slot 0 first), one pair per cycle, while the buffer holds data.
REQ-022 Outputs are registered: the first pair of an accepted word appears with enable_out=1 in the cycle after the edge following the transfer edge (latency 2 edges, no bubble when the next word is already buffered).
REQ-023 enable_out=0 with weight_out=trit_out=00 whenever no pair issues (stall, IDLE, DONE).
REQ-024 A remaining-pair counter loads tile_len on start and decrements per issued pair; the pair issued at count 1 is the last.
REQ-025 Slots beyond the last pair of the final word are discarded; the buffer is marked empty at tile end.
REQ-026 Any slot code 2'b11 (weight or input) is issued as 00 and increments invalid_count by one per offending trit, saturating at all-ones; invalid_count persists across tiles.
REQ-027 tile_done pulses in DONE, i.e. the cycle after the last enable_out=1 cycle (or the cycle after start for tile_len==0); busy=1 in STREAM and DONE.

Reset
REQ-028 reset forces IDLE, empties buffer, clears pointer and counters; s_ready, weight_out, trit_out, enable_out, busy, tile_done = 0; invalid_count = 0.
REQ-029 reset mid-tile aborts without tile_done; a word presented during reset is not accepted.

Structure
REQ-030 Trit encoding constants (ZERO, POS, NEG, ILLEGAL) and the state enumeration reside in the shared ternary package also used by the lane ALU.
REQ-031 One sub-module, ternary_trit_sanitizer: combinational 2-bit code check returning cleaned trit and an illegal flag, instanced for weight and input.

Verification
REQ-032 tile_len=16, one word weights all 01, inputs slot k = 01 (k even) / 10 (k odd) -> 16 consecutive enable_out cycles alternating trit_out 01/10, tile_done next cycle.
REQ-033 tile_len=40, three words offered continuously -> exactly 40 contiguous enable_out cycles, third word slots 8-15 discarded, s_ready low after third transfer.
REQ-034 tile_len=20, s_valid dropped 3 cycles after first word -> enable_out low (outputs 00) during stall, 20 pairs total in order.
REQ-035 Word with slots 2 and 5 weight 11 and slot 5 input 11 -> those slots issue 00, invalid_count=3.
REQ-036 start with tile_len=0 -> tile_done one cycle later, no transfer, enable_out never 1; start during STREAM ignored.
REQ-037 reset asserted after 7 of 16 pairs -> all outputs 0 next cycle, no tile_done, new start then runs a full tile correctly.
